// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the stream FIFO: capacity derivation from the top-level parameters.
package stream_fifo_pkg;

    function automatic int fifo_capacity(input int depth_bits, input int output_reg);
        return (1 << depth_bits) + ((output_reg != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int data_width = 32,
    parameter int addr_bits  = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_bits-1:0]  waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_bits-1:0]  raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [0:(1<<addr_bits)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with first-word-fall-through and an optional registered output stage.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int data_width         = 32,
    parameter int depth_bits         = 4,
    parameter int output_reg         = 0,
    parameter int almost_full_level  = (1 << depth_bits) - 1,
    parameter int almost_empty_level = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [depth_bits:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int CAP = fifo_capacity(depth_bits, output_reg);
    localparam logic [depth_bits:0]   CAP_L  = CAP[depth_bits:0];
    localparam logic [depth_bits:0]   AF_L   = almost_full_level[depth_bits:0];
    localparam logic [depth_bits:0]   AE_L   = almost_empty_level[depth_bits:0];
    localparam logic [depth_bits:0]   LVL_1  = (depth_bits+1)'(1);
    localparam logic [depth_bits-1:0] PTR_1  = depth_bits'(1);

    logic                  push, pop;
    logic                  mem_we;
    logic [depth_bits-1:0] wr_ptr, rd_ptr;
    logic [data_width-1:0] rd_data;

    assign in_ready     = (level < CAP_L);
    assign out_valid    = (level != '0);
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   level <= '0;
        else if (flush) level <= '0;
        else begin
            case ({push, pop})
                2'b10:   level <= level + LVL_1;
                2'b01:   level <= level - LVL_1;
                default: level <= level;
            endcase
        end
    end

    fifo_mem #(.data_width(data_width), .addr_bits(depth_bits)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    generate
        if (output_reg == 0) begin : g_comb_out
            assign mem_we   = push && !flush;
            assign out_data = rd_data;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + PTR_1;
                    if (pop)  rd_ptr <= rd_ptr + PTR_1;
                end
            end
        end else begin : g_reg_out
            logic                  oreg_valid;
            logic [data_width-1:0] oreg_data;
            logic [depth_bits:0]   mem_count;
            logic                  load, mem_rd, bypass;

            // The output register refills whenever it is empty or draining; an
            // empty memory lets the incoming word skip straight into it.
            assign load     = !oreg_valid || pop;
            assign mem_rd   = load && (mem_count != '0);
            assign bypass   = load && push && (mem_count == '0);
            assign mem_we   = push && !bypass && !flush;
            assign out_data = oreg_data;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    mem_count  <= '0;
                    oreg_valid <= 1'b0;
                end else if (flush) begin
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    mem_count  <= '0;
                    oreg_valid <= 1'b0;
                end else begin
                    if (mem_we) wr_ptr <= wr_ptr + PTR_1;
                    if (mem_rd) rd_ptr <= rd_ptr + PTR_1;
                    case ({mem_we, mem_rd})
                        2'b10:   mem_count <= mem_count + LVL_1;
                        2'b01:   mem_count <= mem_count - LVL_1;
                        default: mem_count <= mem_count;
                    endcase
                    if (load) oreg_valid <= mem_rd || bypass;
                end
            end

            always_ff @(posedge clk) begin
                if (!flush && mem_rd)      oreg_data <= rd_data;
                else if (!flush && bypass) oreg_data <= in_data;
            end
        end
    endgenerate

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: both output modes driven in lockstep, checked against queue models.
module tb_stream_fifo;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            flush = 1'b0;
    logic [7:0]      in_data = '0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [1:0]      in_ready, out_valid, almost_full, almost_empty;
    logic [1:0][7:0] out_data;
    logic [1:0][2:0] level;

    int    total = 0;
    int    passed = 0;
    string phase = "reset";
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    stream_fifo #(.data_width(8), .depth_bits(2), .output_reg(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready[0]), .out_data(out_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .level(level[0]),
        .almost_full(almost_full[0]), .almost_empty(almost_empty[0])
    );

    stream_fifo #(.data_width(8), .depth_bits(2), .output_reg(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready[1]), .out_data(out_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .level(level[1]),
        .almost_full(almost_full[1]), .almost_empty(almost_empty[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int msize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] mfront(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    // Model: capacity 4 without the output stage, 5 with it; pop and push judged on pre-edge occupancy.
    task automatic mstep(input int k);
        int  n;
        bit  pu, po;
        n  = msize(k);
        pu = in_valid && (n < 4 + k);
        po = (n != 0) && out_ready;
        if (!reset_n || flush) begin
            if (k == 0) q0.delete(); else q1.delete();
        end else begin
            if (k == 0) begin
                if (po) void'(q0.pop_front());
                if (pu) q0.push_back(in_data);
            end else begin
                if (po) void'(q1.pop_front());
                if (pu) q1.push_back(in_data);
            end
        end
    endtask

    task automatic check_dut(input int k);
        int n;
        n = msize(k);
        chk($sformatf("%s.d%0d.level", phase, k), {29'd0, level[k]}, n);
        chk($sformatf("%s.d%0d.out_valid", phase, k), {31'd0, out_valid[k]}, {31'd0, n != 0});
        chk($sformatf("%s.d%0d.in_ready", phase, k), {31'd0, in_ready[k]}, {31'd0, n < 4 + k});
        chk($sformatf("%s.d%0d.almost_full", phase, k), {31'd0, almost_full[k]}, {31'd0, n >= 3});
        chk($sformatf("%s.d%0d.almost_empty", phase, k), {31'd0, almost_empty[k]}, {31'd0, n <= 1});
        if (n != 0)
            chk($sformatf("%s.d%0d.out_data", phase, k), {24'd0, out_data[k]}, {24'd0, mfront(k)});
    endtask

    task automatic tick();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
    endtask

    initial begin
        logic [7:0] fill_vals [5];
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        tick();
        reset_n = 1'b1;

        phase = "fill";
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = fill_vals[i];
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("fill.d0.level", {29'd0, level[0]}, 4);
        chk("fill.d1.level", {29'd0, level[1]}, 5);
        chk("fill.d0.in_ready", {31'd0, in_ready[0]}, 0);
        chk("fill.d1.in_ready", {31'd0, in_ready[1]}, 0);
        chk("fill.d0.head", {24'd0, out_data[0]}, 32'h11);
        chk("fill.d1.head", {24'd0, out_data[1]}, 32'h11);

        phase = "drain";
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("drain.d0.out_valid", {31'd0, out_valid[0]}, 0);
        chk("drain.d1.out_valid", {31'd0, out_valid[1]}, 0);

        phase = "concur";
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'h55; out_ready = 1'b1; tick();
        chk("concur.d0.level", {29'd0, level[0]}, 2);
        chk("concur.d0.head", {24'd0, out_data[0]}, 32'hA2);
        chk("concur.d1.level", {29'd0, level[1]}, 2);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        phase = "wrap";
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(i);
            tick();
            chk("wrap.d0.level_le1", {31'd0, level[0] <= 3'd1}, 1);
            chk("wrap.d0.no_bubble", {31'd0, out_valid[0]}, 1);
            chk("wrap.d0.data", {24'd0, out_data[0]}, i);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        phase = "flush";
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC0 + 8'(i);
            tick();
        end
        flush = 1'b1; in_data = 8'h99; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.d0.level", {29'd0, level[0]}, 0);
        chk("flush.d1.level", {29'd0, level[1]}, 0);
        chk("flush.d0.out_valid", {31'd0, out_valid[0]}, 0);
        chk("flush.d1.out_valid", {31'd0, out_valid[1]}, 0);
        in_valid = 1'b1; in_data = 8'h5A; tick();
        in_valid = 1'b0; tick();
        chk("flush.d0.next", {24'd0, out_data[0]}, 32'h5A);
        chk("flush.d1.next", {24'd0, out_data[1]}, 32'h5A);

        phase = "reset";
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 8'hE0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("reset.d0.pre_level", {29'd0, level[0]}, 3);
        #1 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset.d%0d.level", k), {29'd0, level[k]}, 0);
            chk($sformatf("reset.d%0d.out_valid", k), {31'd0, out_valid[k]}, 0);
            chk($sformatf("reset.d%0d.in_ready", k), {31'd0, in_ready[k]}, 1);
            chk($sformatf("reset.d%0d.almost_full", k), {31'd0, almost_full[k]}, 0);
            chk($sformatf("reset.d%0d.almost_empty", k), {31'd0, almost_empty[k]}, 1);
        end
        q0.delete();
        q1.delete();
        #1 reset_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h77; tick();
        in_valid = 1'b0; tick();
        chk("reset.d0.first_push", {24'd0, out_data[0]}, 32'h77);
        chk("reset.d1.first_push", {24'd0, out_data[1]}, 32'h77);
        chk("reset.d0.level", {29'd0, level[0]}, 1);

        phase = "random";
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            in_data   = 8'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
